// File: rtl/mv_host_sequencer.sv
// PL-side host for the matrix-vector accelerator: loads x/W BRAMs from a
// stream, clears y, runs the accelerator handshake and streams y back out.
module mv_host_sequencer #(
    parameter int length_M    = 512,
    parameter int length_N    = 32,
    parameter int addr_W_size = 15,
    parameter int addr_x_size = 12,
    parameter int addr_y_size = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [31:0]            m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [addr_x_size-1:0] bram_addr_x,
    output logic [31:0]            bram_wrdata_x,
    output logic [3:0]             bram_we_x,
    output logic [addr_W_size-1:0] bram_addr_W1,
    output logic [31:0]            bram_wrdata_W1,
    output logic [3:0]             bram_we_W1,
    output logic [addr_W_size-1:0] bram_addr_W2,
    output logic [31:0]            bram_wrdata_W2,
    output logic [3:0]             bram_we_W2,
    output logic [addr_y_size-1:0] bram_addr_y1,
    output logic [31:0]            bram_wrdata_y1,
    output logic [3:0]             bram_we_y1,
    input  logic [31:0]            bram_rddata_y1,
    output logic [addr_y_size-1:0] bram_addr_y2,
    output logic [31:0]            bram_wrdata_y2,
    output logic [3:0]             bram_we_y2,
    input  logic [31:0]            bram_rddata_y2,
    output logic [31:0]            ps_control,
    input  logic [31:0]            pl_status
);

    localparam int HALF = length_M / 2;
    localparam int CW   = $clog2(length_N + 1);
    localparam int GW   = $clog2(length_M + 1);
    localparam int IW   = $clog2(HALF + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_X, S_LOAD_W, S_CLEAR_Y, S_RUN,
        S_RELEASE, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] col;
    logic [GW-1:0] row_g;
    logic [IW-1:0] idx;
    logic          rd_bank;

    logic          load_st, accept;
    logic          col_last, g_last, idx_last;
    logic          w_bank;
    logic [GW-1:0] w_row;
    logic [31:0]   w_word;
    logic [addr_W_size-1:0] w_addr;
    logic [addr_x_size-1:0] x_addr;
    logic [addr_y_size-1:0] y_addr;
    logic          unused_status;

    assign unused_status = ^pl_status[31:1];

    assign load_st  = (state == S_LOAD_X) || (state == S_LOAD_W);
    assign accept   = s_valid & load_st;
    assign col_last = col == CW'(length_N - 1);
    assign g_last   = row_g == GW'(length_M - 1);
    assign idx_last = idx == IW'(HALF - 1);

    // Upper half of the global rows lives in the second W bank.
    assign w_bank = row_g >= GW'(HALF);
    assign w_row  = w_bank ? row_g - GW'(HALF) : row_g;
    assign w_word = 32'(w_row) * 32'(length_N) + 32'(col);
    assign w_addr = addr_W_size'({w_word, 2'b00});
    assign x_addr = addr_x_size'({col, 2'b00});
    assign y_addr = addr_y_size'({idx, 2'b00});

    assign s_ready    = load_st;
    assign busy       = state != S_IDLE;
    assign done       = state == S_DONE;
    assign m_valid    = state == S_RD_OUT;
    assign ps_control = {31'd0, state == S_RUN};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bram_addr_x    = '0;
        bram_wrdata_x  = '0;
        bram_we_x      = '0;
        bram_addr_W1   = '0;
        bram_wrdata_W1 = '0;
        bram_we_W1     = '0;
        bram_addr_W2   = '0;
        bram_wrdata_W2 = '0;
        bram_we_W2     = '0;
        bram_addr_y1   = '0;
        bram_wrdata_y1 = '0;
        bram_we_y1     = '0;
        bram_addr_y2   = '0;
        bram_wrdata_y2 = '0;
        bram_we_y2     = '0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_LOAD_X;
            S_LOAD_X: begin
                bram_addr_x = x_addr;
                if (accept) begin
                    bram_we_x     = 4'hF;
                    bram_wrdata_x = s_data;
                    if (col_last) state_nx = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_bank) bram_addr_W2 = w_addr;
                else        bram_addr_W1 = w_addr;
                if (accept) begin
                    if (w_bank) begin
                        bram_we_W2     = 4'hF;
                        bram_wrdata_W2 = s_data;
                    end else begin
                        bram_we_W1     = 4'hF;
                        bram_wrdata_W1 = s_data;
                    end
                    if (col_last && g_last) state_nx = S_CLEAR_Y;
                end
            end
            S_CLEAR_Y: begin
                bram_addr_y1 = y_addr;
                bram_addr_y2 = y_addr;
                bram_we_y1   = 4'hF;
                bram_we_y2   = 4'hF;
                if (idx_last) state_nx = S_RUN;
            end
            S_RUN:     if (pl_status[0]) state_nx = S_RELEASE;
            S_RELEASE: if (!pl_status[0]) state_nx = S_RD_ADDR;
            S_RD_ADDR, S_RD_WAIT: begin
                // Address is held through the wait cycle for the 1-cycle read.
                if (rd_bank) bram_addr_y2 = y_addr;
                else         bram_addr_y1 = y_addr;
                state_nx = (state == S_RD_ADDR) ? S_RD_WAIT : S_RD_OUT;
            end
            S_RD_OUT: begin
                if (m_ready) begin
                    state_nx = (rd_bank && idx_last) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            row_g   <= '0;
            idx     <= '0;
            rd_bank <= 1'b0;
            m_data  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        col     <= '0;
                        row_g   <= '0;
                        idx     <= '0;
                        rd_bank <= 1'b0;
                    end
                end
                S_LOAD_X: if (accept) col <= col_last ? '0 : col + CW'(1);
                S_LOAD_W: begin
                    if (accept) begin
                        if (col_last) begin
                            col   <= '0;
                            row_g <= row_g + GW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_CLEAR_Y: idx <= idx_last ? '0 : idx + IW'(1);
                S_RD_WAIT: m_data <= rd_bank ? bram_rddata_y2 : bram_rddata_y1;
                S_RD_OUT: begin
                    if (m_ready) begin
                        if (idx_last) begin
                            idx     <= '0;
                            rd_bank <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mv_host_sequencer.sv
// Directed bench for mv_host_sequencer at M=4, N=2 with BRAM and
// accelerator models.
module tb_mv_host_sequencer;

    localparam logic [31:0] ONE = 32'h3F800000;

    logic        clk = 1'b0;
    logic        reset, start, s_valid, m_ready;
    logic [31:0] s_data, pl_status;
    logic        busy, done, s_ready, m_valid;
    logic [31:0] m_data, ps_control;
    logic [11:0] bram_addr_x, bram_addr_y1, bram_addr_y2;
    logic [14:0] bram_addr_W1, bram_addr_W2;
    logic [31:0] bram_wrdata_x, bram_wrdata_W1, bram_wrdata_W2;
    logic [31:0] bram_wrdata_y1, bram_wrdata_y2;
    logic [3:0]  bram_we_x, bram_we_W1, bram_we_W2, bram_we_y1, bram_we_y2;
    logic [31:0] rd_y1 = '0, rd_y2 = '0;

    mv_host_sequencer #(.length_M(4), .length_N(2)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .bram_addr_x(bram_addr_x), .bram_wrdata_x(bram_wrdata_x),
        .bram_we_x(bram_we_x),
        .bram_addr_W1(bram_addr_W1), .bram_wrdata_W1(bram_wrdata_W1),
        .bram_we_W1(bram_we_W1),
        .bram_addr_W2(bram_addr_W2), .bram_wrdata_W2(bram_wrdata_W2),
        .bram_we_W2(bram_we_W2),
        .bram_addr_y1(bram_addr_y1), .bram_wrdata_y1(bram_wrdata_y1),
        .bram_we_y1(bram_we_y1), .bram_rddata_y1(rd_y1),
        .bram_addr_y2(bram_addr_y2), .bram_wrdata_y2(bram_wrdata_y2),
        .bram_we_y2(bram_we_y2), .bram_rddata_y2(rd_y2),
        .ps_control(ps_control), .pl_status(pl_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          port;
        logic [31:0] addr;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] exp_y [4];
    int          total = 0, bad = 0;
    int          we_cycles = 0, we_viol = 0;

    logic [31:0] xm [16], w1m [16], w2m [16], y1m [16], y2m [16];
    logic [31:0] y1_pre [16], y2_pre [16];
    bit          pre_go = 0, fill_go = 0;
    logic [3:0]  pend1 = '0, pend2 = '0;

    // BRAM models: sample the DUT ports mid-cycle, update read data on the edge.
    always @(negedge clk) begin
        if (fill_go) begin
            for (int i = 0; i < 16; i++) begin
                xm[i] = 32'hDEADBEEF; w1m[i] = 32'hDEADBEEF;
                w2m[i] = 32'hDEADBEEF; y1m[i] = 32'hDEADBEEF;
                y2m[i] = 32'hDEADBEEF;
            end
        end
        if (pre_go) begin
            for (int i = 0; i < 16; i++) begin
                y1m[i] = y1_pre[i];
                y2m[i] = y2_pre[i];
            end
        end
        if (!reset) begin
            if ((bram_we_x | bram_we_W1 | bram_we_W2) != 4'h0) we_cycles++;
            if (((bram_we_x | bram_we_W1 | bram_we_W2) != 4'h0) != (s_valid && s_ready))
                we_viol++;
        end
        if (bram_we_x == 4'hF)  xm[bram_addr_x[5:2]]   = bram_wrdata_x;
        if (bram_we_W1 == 4'hF) w1m[bram_addr_W1[5:2]] = bram_wrdata_W1;
        if (bram_we_W2 == 4'hF) w2m[bram_addr_W2[5:2]] = bram_wrdata_W2;
        if (bram_we_y1 == 4'hF) y1m[bram_addr_y1[5:2]] = bram_wrdata_y1;
        if (bram_we_y2 == 4'hF) y2m[bram_addr_y2[5:2]] = bram_wrdata_y2;
        pend1 = bram_addr_y1[5:2];
        pend2 = bram_addr_y2[5:2];
    end

    always @(posedge clk) begin
        rd_y1 <= y1m[pend1];
        rd_y2 <= y2m[pend2];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_at(input int port, input logic [31:0] addr);
        if (port == 0)      return xm[addr[5:2]];
        else if (port == 1) return w1m[addr[5:2]];
        else                return w2m[addr[5:2]];
    endfunction

    task automatic fill_mems;
        fill_go = 1; tick; fill_go = 0;
    endtask

    task automatic do_load(input bit gaps, input bit ones, input bit poke);
        logic [3:0]  we;
        logic [31:0] a, d, e;
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                s_valid = 0; s_data = 32'hBAD0BAD0; tick;
            end
            e = ones ? ONE : tbl[i].data;
            s_valid = 1; s_data = e;
            #1;
            if (tbl[i].port == 0) begin
                we = bram_we_x; a = 32'(bram_addr_x); d = bram_wrdata_x;
            end else if (tbl[i].port == 1) begin
                we = bram_we_W1; a = 32'(bram_addr_W1); d = bram_wrdata_W1;
            end else begin
                we = bram_we_W2; a = 32'(bram_addr_W2); d = bram_wrdata_W2;
            end
            chk("ld_ready", 32'(s_ready), 1);
            chk("ld_we", 32'(we), 32'hF);
            chk("ld_addr", a, tbl[i].addr);
            chk("ld_data", d, e);
            start = poke && (i == 5);
            tick;
            start = 0;
        end
        s_valid = 0;
    endtask

    task automatic accel(input bit compute);
        int n, cnt;
        logic [31:0] w;
        logic [31:0] lut [3];
        lut[0] = 32'h0; lut[1] = ONE; lut[2] = 32'h40000000;
        n = 0;
        while (ps_control[0] !== 1'b1 && n < 50) begin tick; n++; end
        chk("run_req", 32'(ps_control[0]), 1);
        if (compute) begin
            for (int g = 0; g < 4; g++) begin
                cnt = 0;
                for (int c = 0; c < 2; c++) begin
                    w = (g < 2) ? w1m[g*2+c] : w2m[(g-2)*2+c];
                    if (xm[c] == ONE && w == ONE) cnt++;
                end
                if (g < 2) y1_pre[g] = lut[cnt];
                else       y2_pre[g-2] = lut[cnt];
            end
            pre_go = 1; tick; pre_go = 0;
        end
        pl_status = 32'd1;
        n = 0;
        while (ps_control[0] !== 1'b0 && n < 50) begin tick; n++; end
        chk("run_drop", 32'(ps_control[0]), 0);
        pl_status = 32'd0;
    endtask

    task automatic read_words(input int stall);
        int n;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            while (m_valid !== 1'b1 && n < 20) begin tick; n++; end
            chk("rd_valid", 32'(m_valid), 1);
            chk("rd_data", m_data, exp_y[w]);
            for (int s = 0; s < stall; s++) begin
                tick;
                chk("rd_hold_valid", 32'(m_valid), 1);
                chk("rd_hold_data", m_data, exp_y[w]);
            end
            m_ready = 1; tick; m_ready = 0;
            if (w < 3) chk("rd_gap", 32'(m_valid), 0);
        end
        chk("done_pulse", 32'(done), 1);
        tick;
        chk("done_clear", 32'(done), 0);
        chk("busy_clear", 32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        tbl[0] = '{32'd0, 0, 32'h0};
        tbl[1] = '{32'd1, 0, 32'h4};
        tbl[2] = '{32'd2, 1, 32'h0};
        tbl[3] = '{32'd3, 1, 32'h4};
        tbl[4] = '{32'd4, 1, 32'h8};
        tbl[5] = '{32'd5, 1, 32'hC};
        tbl[6] = '{32'd6, 2, 32'h0};
        tbl[7] = '{32'd7, 2, 32'h4};
        tbl[8] = '{32'd8, 2, 32'h8};
        tbl[9] = '{32'd9, 2, 32'hC};

        reset = 1; start = 0; s_valid = 0; m_ready = 0;
        s_data = 0; pl_status = 0;
        tick; tick; tick;
        reset = 0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_ps_control", ps_control, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_we", {12'd0, bram_we_x, bram_we_W1, bram_we_W2, bram_we_y1, bram_we_y2}, 0);
        chk("rst_addr_xy", {8'd0, bram_addr_x, bram_addr_y1}, 0);
        chk("rst_addr_w", {2'd0, bram_addr_W1, bram_addr_W2}, 0);

        // Job 1: continuous stream, then run/release and stalled readout.
        fill_mems;
        n0 = we_cycles;
        start = 1; tick; start = 0;
        chk("busy_load", 32'(busy), 1);
        do_load(0, 0, 0);
        chk("clr_s_ready", 32'(s_ready), 0);
        for (int k = 0; k < 2; k++) begin
            chk("clr_we", {24'd0, bram_we_y1, bram_we_y2}, 32'hFF);
            chk("clr_addr1", 32'(bram_addr_y1), 32'(k*4));
            chk("clr_addr2", 32'(bram_addr_y2), 32'(k*4));
            chk("clr_data", bram_wrdata_y1 | bram_wrdata_y2, 0);
            tick;
        end
        chk("load_we_cycles", 32'(we_cycles - n0), 10);
        for (int i = 0; i < 10; i++)
            chk("mem_job1", mem_at(tbl[i].port, tbl[i].addr), tbl[i].data);
        chk("y1_cleared", y1m[0] | y1m[1], 0);
        chk("y2_cleared", y2m[0] | y2m[1], 0);
        chk("y1_beyond", y1m[2], 32'hDEADBEEF);
        y1_pre[0] = 32'h3F800000; y1_pre[1] = 32'h40000000;
        y2_pre[0] = 32'h40400000; y2_pre[1] = 32'h40800000;
        for (int k = 0; k < 10; k++) begin
            chk("run_ps", ps_control, 1);
            chk("run_s_ready", 32'(s_ready), 0);
            pre_go = (k == 0);
            tick;
        end
        pre_go = 0;
        pl_status = 32'd1;
        tick;
        chk("rel_ps", ps_control, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("rel_hold_ps", ps_control, 0);
            chk("rel_no_out", 32'(m_valid), 0);
            chk("rel_no_rd", 32'(bram_addr_y1 | bram_addr_y2), 0);
        end
        pl_status = 32'd0;
        tick;
        exp_y[0] = 32'h3F800000; exp_y[1] = 32'h40000000;
        exp_y[2] = 32'h40400000; exp_y[3] = 32'h40800000;
        read_words(5);

        // Job 2: s_valid toggles; only accept cycles may write.
        fill_mems;
        start = 1; tick; start = 0;
        do_load(1, 0, 0);
        chk("clr2_s_ready", 32'(s_ready), 0);
        tick; tick;
        for (int i = 0; i < 10; i++)
            chk("mem_job2", mem_at(tbl[i].port, tbl[i].addr), tbl[i].data);
        accel(0);
        for (int i = 0; i < 4; i++) exp_y[i] = 32'h0;
        read_words(0);

        // Reset in the middle of LOAD_W aborts, a new job restarts at x[0].
        start = 1; tick; start = 0;
        s_valid = 1;
        for (int k = 0; k < 5; k++) begin
            s_data = 32'(100 + k); tick;
        end
        s_valid = 0; reset = 1;
        tick;
        chk("abort_ps", ps_control, 0);
        chk("abort_we", {12'd0, bram_we_x, bram_we_W1, bram_we_W2, bram_we_y1, bram_we_y2}, 0);
        chk("abort_s_ready", 32'(s_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        reset = 0;
        tick;
        start = 1; tick; start = 0;
        s_valid = 1; s_data = 32'h77; #1;
        chk("restart_we", 32'(bram_we_x), 32'hF);
        chk("restart_addr", 32'(bram_addr_x), 0);
        tick;
        s_valid = 0; reset = 1; tick; reset = 0; tick;

        // Job 3: all-ones end to end, with a stray start mid-load.
        fill_mems;
        start = 1; tick; start = 0;
        do_load(0, 1, 1);
        tick; tick;
        accel(1);
        for (int i = 0; i < 4; i++) exp_y[i] = 32'h40000000;
        read_words(0);
        tick; tick; tick;
        chk("no_requeue", 32'(busy), 0);

        chk("we_only_on_accept", 32'(we_viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
